// File: rtl/tree_mac_acc_stream.sv
// tree_mac_acc_stream: streaming tree multiply-accumulate core.
// Each accepted beat multiplies two DATA_LENGTH-element vectors element-wise.
// A registered TREE_BASE-ary adder tree then reduces the products at ACC_WIDTH.
// Beats are accumulated across a packet that closes on last_in.
// Optional feature macro: TREE_MAC_SATURATE_EN makes the accumulator add saturate.
// Without the macro, all arithmetic wraps modulo 2^ACC_WIDTH.
// The reset port is asynchronous and active-low.
module tree_mac_acc_stream #(
    parameter int DATA_WIDTH      = 8,
    parameter int DATA_LENGTH     = 64,
    parameter int TREE_BASE       = 2,
    parameter int ACC_WIDTH       = 32,
    parameter int ADDRESS_WIDTH_I = 8,
    parameter int ADDRESS_WIDTH_K = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH*DATA_LENGTH-1:0] row,
    input  logic [DATA_WIDTH*DATA_LENGTH-1:0] col,
    input  logic                              signed_in,
    input  logic                              last_in,
    input  logic [ADDRESS_WIDTH_I-1:0]        addr_i_in,
    input  logic [ADDRESS_WIDTH_K-1:0]        addr_k_in,
    input  logic                              val_in,
    output logic                              in_ready,
    output logic [ACC_WIDTH-1:0]              sum_out,
    output logic [ADDRESS_WIDTH_I-1:0]        addr_i_out,
    output logic [ADDRESS_WIDTH_K-1:0]        addr_k_out,
    output logic                              val_out,
    input  logic                              out_ready
);

    function automatic int clog_base(input int n, input int b);
        int levels;
        int span;
        levels = 0;
        span   = 1;
        while (span < n) begin
            span   = span * b;
            levels = levels + 1;
        end
        return levels;
    endfunction

    function automatic logic [ACC_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] x, input logic sgn);
        return sgn ? {{(ACC_WIDTH-DATA_WIDTH){x[DATA_WIDTH-1]}}, x}
                   : {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, x};
    endfunction

    localparam int LEVELS = clog_base(DATA_LENGTH, TREE_BASE);
    localparam int TAIL   = LEVELS + 1;

    // A result waiting on a busy consumer freezes the whole pipeline
    logic en;
    assign en       = !(val_out && !out_ready);
    assign in_ready = en && reset;

    logic [DATA_WIDTH*DATA_LENGTH-1:0] row_r, col_r;
    logic [ACC_WIDTH-1:0]              prod_c [0:DATA_LENGTH-1];
    logic [ACC_WIDTH-1:0]              prod_r [0:DATA_LENGTH-1];

    logic                       v_p    [0:TAIL];
    logic                       sgn_p  [0:TAIL];
    logic                       last_p [0:TAIL];
    logic [ADDRESS_WIDTH_I-1:0] ai_p   [0:TAIL];
    logic [ADDRESS_WIDTH_K-1:0] ak_p   [0:TAIL];

    // Tags and valid bits walk alongside the data, one stage per enabled cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k <= TAIL; k++) begin
                v_p[k]    <= 1'b0;
                sgn_p[k]  <= 1'b0;
                last_p[k] <= 1'b0;
                ai_p[k]   <= '0;
                ak_p[k]   <= '0;
            end
        end else if (en) begin
            v_p[0]    <= val_in;
            sgn_p[0]  <= signed_in;
            last_p[0] <= last_in;
            ai_p[0]   <= addr_i_in;
            ak_p[0]   <= addr_k_in;
            for (int k = 1; k <= TAIL; k++) begin
                v_p[k]    <= v_p[k-1];
                sgn_p[k]  <= sgn_p[k-1];
                last_p[k] <= last_p[k-1];
                ai_p[k]   <= ai_p[k-1];
                ak_p[k]   <= ak_p[k-1];
            end
        end
    end

    // Operand input register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_r <= '0;
            col_r <= '0;
        end else if (en) begin
            row_r <= row;
            col_r <= col;
        end
    end

    // Full-width products; extension follows the beat's signed flag
    always_comb begin
        for (int e = 0; e < DATA_LENGTH; e++) begin
            prod_c[e] = extend(row_r[e*DATA_WIDTH +: DATA_WIDTH], sgn_p[0])
                      * extend(col_r[e*DATA_WIDTH +: DATA_WIDTH], sgn_p[0]);
        end
    end

    // Product register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < DATA_LENGTH; e++) prod_r[e] <= '0;
        end else if (en) begin
            for (int e = 0; e < DATA_LENGTH; e++) prod_r[e] <= prod_c[e];
        end
    end

    for (genvar l = 0; l <= LEVELS; l++) begin : lvl
        localparam int NODES = TREE_BASE ** (LEVELS - l);
        logic [ACC_WIDTH-1:0] node [0:NODES-1];
        if (l == 0) begin : leaf
            for (genvar n = 0; n < NODES; n++) begin : pad
                if (n < DATA_LENGTH) begin : used
                    assign node[n] = prod_r[n];
                end else begin : zero
                    assign node[n] = '0;
                end
            end
        end else begin : add
            logic [ACC_WIDTH-1:0] node_sum [0:NODES-1];
            // Each node adds TREE_BASE children from the level below
            always_comb begin
                for (int n = 0; n < NODES; n++) begin
                    node_sum[n] = '0;
                    for (int j = 0; j < TREE_BASE; j++) begin
                        node_sum[n] = node_sum[n] + lvl[l-1].node[n*TREE_BASE + j];
                    end
                end
            end
            // One register per tree level
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int n = 0; n < NODES; n++) node[n] <= '0;
                end else if (en) begin
                    for (int n = 0; n < NODES; n++) node[n] <= node_sum[n];
                end
            end
        end
    end

    logic [ACC_WIDTH-1:0] tree_sum, acc, acc_add, acc_next;
    logic                 first;
    assign tree_sum = lvl[LEVELS].node[0];

`ifdef TREE_MAC_SATURATE_EN
    logic [ACC_WIDTH:0] wide;
    // Add with one guard bit and clamp to the range of the incoming beat's signedness
    always_comb begin
        if (sgn_p[TAIL]) wide = {acc[ACC_WIDTH-1], acc} + {tree_sum[ACC_WIDTH-1], tree_sum};
        else             wide = {1'b0, acc} + {1'b0, tree_sum};
        acc_add = wide[ACC_WIDTH-1:0];
        if (sgn_p[TAIL] && (wide[ACC_WIDTH] != wide[ACC_WIDTH-1])) begin
            acc_add = wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else if (!sgn_p[TAIL] && wide[ACC_WIDTH]) begin
            acc_add = '1;
        end
    end
`else
    assign acc_add = acc + tree_sum;
`endif

    assign acc_next = first ? tree_sum : acc_add;

    // Accumulate across a packet; the closing beat publishes the result and rearms
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc        <= '0;
            first      <= 1'b1;
            sum_out    <= '0;
            addr_i_out <= '0;
            addr_k_out <= '0;
            val_out    <= 1'b0;
        end else begin
            if (val_out && out_ready) val_out <= 1'b0;
            if (en && v_p[TAIL]) begin
                if (last_p[TAIL]) begin
                    sum_out    <= acc_next;
                    addr_i_out <= ai_p[TAIL];
                    addr_k_out <= ak_p[TAIL];
                    val_out    <= 1'b1;
                    acc        <= '0;
                    first      <= 1'b1;
                end else begin
                    acc   <= acc_next;
                    first <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tree_mac_acc_stream.sv
// tb_tree_mac_acc_stream: directed, table-driven bench for tree_mac_acc_stream.
// Configuration: DATA_LENGTH=4, TREE_BASE=2, DATA_WIDTH=8, ACC_WIDTH=20.
// This gives two tree levels and five register stages from input to result.
// The saturation expectations follow TREE_MAC_SATURATE_EN.
module tb_tree_mac_acc_stream;

    localparam int DW = 8;
    localparam int DL = 4;
    localparam int AW = 20;

    logic           clk = 1'b0;
    logic           reset;
    logic [DW*DL-1:0] row, col;
    logic           signed_in, last_in, val_in, out_ready;
    logic [7:0]     addr_i_in, addr_k_in;
    logic           in_ready, val_out;
    logic [AW-1:0]  sum_out;
    logic [7:0]     addr_i_out, addr_k_out;

    int total = 0;
    int bad = 0;
    int results = 0;

    typedef struct {
        logic [31:0] row;
        logic [31:0] col;
        logic        sgn;
        logic [7:0]  ai;
        logic [7:0]  ak;
        logic [19:0] exp_sum;
    } vec_t;

    vec_t vecs [6];

    tree_mac_acc_stream #(
        .DATA_WIDTH(DW), .DATA_LENGTH(DL), .TREE_BASE(2), .ACC_WIDTH(AW),
        .ADDRESS_WIDTH_I(8), .ADDRESS_WIDTH_K(8)
    ) dut (
        .clk(clk), .reset(reset), .row(row), .col(col), .signed_in(signed_in),
        .last_in(last_in), .addr_i_in(addr_i_in), .addr_k_in(addr_k_in),
        .val_in(val_in), .in_ready(in_ready), .sum_out(sum_out),
        .addr_i_out(addr_i_out), .addr_k_out(addr_k_out), .val_out(val_out),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Count completed result handshakes
    always @(posedge clk) begin
        if (val_out && out_ready) results <= results + 1;
    end

    // Hard stop if the sequence ever hangs
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] r, input logic [31:0] c, input logic s,
                                 input logic lst, input logic [7:0] ai, input logic [7:0] ak);
        row       = r;
        col       = c;
        signed_in = s;
        last_in   = lst;
        addr_i_in = ai;
        addr_k_in = ak;
        val_in    = 1'b1;
        tick();
        val_in    = 1'b0;
        last_in   = 1'b0;
    endtask

    task automatic sendPacket(input int beats, input logic [31:0] r, input logic [31:0] c,
                              input logic s, input logic [7:0] ai, input logic [7:0] ak);
        for (int b = 0; b < beats; b++) begin
            applyStimulus(r, c, s, (b == beats - 1), ai, ak);
        end
    endtask

    task automatic waitResult(input int bound, output int cycles);
        cycles = 0;
        while (!val_out && cycles < bound) begin
            tick();
            cycles++;
        end
        checkOutput("result_seen", 32'(val_out), 32'd1);
    endtask

    int cyc;
    int r0;
    logic early;

    initial begin
        // Hand-computed single-beat vectors
        vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 8'd3, 8'd7, 20'd260100};
        vecs[1] = '{{8'hFF, 8'h02, 8'hFD, 8'h04}, 32'h05050505, 1'b1, 8'd1, 8'd2, 20'd10};
        vecs[2] = '{{8'hFF, 8'h02, 8'hFD, 8'h04}, 32'h05050505, 1'b0, 8'd4, 8'd5, 20'd2570};
        vecs[3] = '{32'h80808080, 32'h80808080, 1'b1, 8'd11, 8'd12, 20'd65536};
        vecs[4] = '{32'h80808080, 32'h7F7F7F7F, 1'b1, 8'd13, 8'd14, 20'd983552};
        vecs[5] = '{32'h00000000, 32'hFFFFFFFF, 1'b0, 8'd15, 8'd16, 20'd0};

        row = '0; col = '0; signed_in = 0; last_in = 0; val_in = 0;
        addr_i_in = 0; addr_k_in = 0; out_ready = 1;
        reset = 1'b0;
        tick();
        tick();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_val_out", 32'(val_out), 32'd0);
        checkOutput("rst_sum_out", 32'(sum_out), 32'd0);
        checkOutput("rst_addr_i", 32'(addr_i_out), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Single-beat packets, with exact latency and one-cycle result
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].row, vecs[i].col, vecs[i].sgn, 1'b1, vecs[i].ai, vecs[i].ak);
            repeat (3) tick();
            checkOutput("vec_early_val", 32'(val_out), 32'd0);
            tick();
            checkOutput("vec_val", 32'(val_out), 32'd1);
            checkOutput("vec_sum", 32'(sum_out), 32'(vecs[i].exp_sum));
            checkOutput("vec_addr_i", 32'(addr_i_out), 32'(vecs[i].ai));
            checkOutput("vec_addr_k", 32'(addr_k_out), 32'(vecs[i].ak));
            tick();
            checkOutput("vec_val_clear", 32'(val_out), 32'd0);
        end

        // Three-beat packet with an idle cycle before the last beat
        r0 = results;
        applyStimulus(32'h01010101, 32'h01010101, 1'b0, 1'b0, 8'd1, 8'd1);
        applyStimulus(32'h01010101, 32'h01010101, 1'b0, 1'b0, 8'd2, 8'd2);
        tick();
        early = (val_out !== 1'b0);
        applyStimulus(32'h01010101, 32'h01010101, 1'b0, 1'b1, 8'd9, 8'd10);
        repeat (3) begin
            if (val_out !== 1'b0) early = 1'b1;
            tick();
        end
        if (val_out !== 1'b0) early = 1'b1;
        checkOutput("pkt_no_early", 32'(early), 32'd0);
        tick();
        checkOutput("pkt_val", 32'(val_out), 32'd1);
        checkOutput("pkt_sum", 32'(sum_out), 32'd12);
        checkOutput("pkt_addr_i", 32'(addr_i_out), 32'd9);
        checkOutput("pkt_addr_k", 32'(addr_k_out), 32'd10);
        repeat (6) tick();
        checkOutput("pkt_count", 32'(results - r0), 32'd1);

        // Backpressure: two back-to-back packets, consumer stalls 4 cycles
        r0 = results;
        applyStimulus(32'h01010101, 32'h02020202, 1'b0, 1'b1, 8'd20, 8'd30);
        applyStimulus(32'h03030303, 32'h01010101, 1'b0, 1'b1, 8'd21, 8'd31);
        repeat (3) tick();
        checkOutput("bp_first_val", 32'(val_out), 32'd1);
        checkOutput("bp_first_sum", 32'(sum_out), 32'd8);
        out_ready = 1'b0;
        #1;
        checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int s = 0; s < 4; s++) begin
            tick();
            checkOutput("bp_stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_hold_val", 32'(val_out), 32'd1);
            checkOutput("bp_hold_sum", 32'(sum_out), 32'd8);
            checkOutput("bp_hold_addr_i", 32'(addr_i_out), 32'd20);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_in_ready_back", 32'(in_ready), 32'd1);
        tick();
        checkOutput("bp_second_val", 32'(val_out), 32'd1);
        checkOutput("bp_second_sum", 32'(sum_out), 32'd12);
        checkOutput("bp_second_addr_i", 32'(addr_i_out), 32'd21);
        checkOutput("bp_second_addr_k", 32'(addr_k_out), 32'd31);
        tick();
        checkOutput("bp_clear", 32'(val_out), 32'd0);
        checkOutput("bp_count", 32'(results - r0), 32'd2);

        // Eight signed beats of 64516 stay inside the 20-bit signed range
        sendPacket(8, 32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1, 8'd40, 8'd41);
        waitResult(10, cyc);
        checkOutput("sat8_sum", 32'(sum_out), 32'd516128);
        tick();

        // A ninth beat pushes past the signed bound
        sendPacket(9, 32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1, 8'd42, 8'd43);
        waitResult(10, cyc);
`ifdef TREE_MAC_SATURATE_EN
        checkOutput("sat9_sum", 32'(sum_out), 32'd524287);
`else
        checkOutput("sat9_sum", 32'(sum_out), 32'd580644);
`endif
        tick();

        // Reset after a partial sum has reached the accumulator
        applyStimulus(32'h01010101, 32'h01010101, 1'b0, 1'b0, 8'd50, 8'd51);
        repeat (6) tick();
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_val", 32'(val_out), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        r0 = results;
        applyStimulus(32'h01010101, 32'h01010101, 1'b0, 1'b1, 8'd5, 8'd6);
        waitResult(10, cyc);
        checkOutput("mid_rst_latency", 32'(cyc), 32'd4);
        checkOutput("mid_rst_sum", 32'(sum_out), 32'd4);
        checkOutput("mid_rst_addr_i", 32'(addr_i_out), 32'd5);
        repeat (5) tick();
        checkOutput("mid_rst_count", 32'(results - r0), 32'd1);

        // Reset while a closing beat is in flight: it must vanish
        r0 = results;
        applyStimulus(32'h02020202, 32'h02020202, 1'b0, 1'b1, 8'd60, 8'd61);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (8) tick();
        checkOutput("inflight_lost", 32'(results - r0), 32'd0);
        checkOutput("inflight_val", 32'(val_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
